// File: rtl/imem_debug_loader_pkg.sv
// Shared definitions for the instruction-RAM debug loader.
//   - loader_state_e : FSM state encoding used by the top
//   - ERR_*          : error codes reported on o_err_code
//   - word_to_byte_addr() : word index -> byte address on the RAM debug port
package imem_debug_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_DRAIN = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } loader_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  // The RAM debug port takes byte addresses with the two low bits zero.
  function automatic logic [31:0] word_to_byte_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_debug_loader_idle_timer.sv
// Idle-cycle timer for the loader's WRITE phase.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : zero the count (wins over i_en)
//   i_en         : count one idle cycle
//   o_expire     : high in the TIMEOUT-th consecutive enabled cycle
module imem_debug_loader_idle_timer #(
  parameter int TIMEOUT = 65535
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  // Expiry is flagged in the cycle that would complete TIMEOUT idle cycles.
  assign o_expire = i_en && !i_clear && (r_cnt == CW'(TIMEOUT - 1));

  // Idle counter: cleared on reset/clear, advanced on each idle cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clear) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_debug_loader.sv
// Write-side master for the instruction RAM debug port. Accepts a valid/ready
// word stream, writes it to consecutive word addresses, optionally reads the
// region back and compares a 32-bit additive checksum. Holds the CPU halted
// for the duration of a load.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : load request, honoured only when idle
//   i_base_addr         : byte address of first word (bits [1:0] ignored)
//   i_word_count        : number of words to load
//   i_s_valid/o_s_ready/i_s_data : host word stream
//   o_dbg_addr/o_dbg_wdata/o_dbg_we/i_dbg_rdata : RAM debug port (1-cycle read latency)
//   o_cpu_halt          : CPU hold while loading
//   o_busy              : not idle
//   o_done              : one-cycle success pulse
//   o_err, o_err_code   : sticky error flag and cause
module imem_debug_loader
  import imem_debug_loader_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int CNT_W     = 13,
  parameter bit VERIFY    = 1'b1,
  parameter int TIMEOUT   = 65535
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [31:0]      i_base_addr,
  input  logic [CNT_W-1:0] i_word_count,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [31:0]      i_s_data,
  output logic [31:0]      o_dbg_addr,
  output logic [31:0]      o_dbg_wdata,
  output logic [3:0]       o_dbg_we,
  input  logic [31:0]      i_dbg_rdata,
  output logic             o_cpu_halt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_err_code
);

  loader_state_e    r_state;
  loader_state_e    w_state_next;
  logic [29:0]      r_base_idx;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_idx;       // word index for both the write and read-back passes
  logic [31:0]      r_wsum;
  logic [31:0]      r_rsum;
  logic             r_rd_pend;   // a read was issued last cycle; its data is on i_dbg_rdata now
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [1:0]       w_err_code_next;

  logic        w_handshake;
  logic        w_last;
  logic [31:0] w_range_end;
  logic        w_range_bad;
  logic [31:0] w_rsum_next;
  logic        w_timer_clear;
  logic        w_timer_en;
  logic        w_timer_expire;
  logic        w_unused_base_lsbs;

  assign w_unused_base_lsbs = ^i_base_addr[1:0];

  // Reset gates the handshake so no RAM write escapes in the reset cycle.
  assign w_handshake = (r_state == ST_WRITE) && i_s_valid && !i_rst;
  assign w_last      = (r_idx == (r_count - CNT_W'(1)));
  // 32-bit sum of a 30-bit index and a CNT_W count cannot wrap.
  assign w_range_end = {2'b00, r_base_idx} + 32'(r_count);
  assign w_range_bad = (w_range_end > 32'(MEM_WORDS));
  assign w_rsum_next = r_rsum + i_dbg_rdata;

  assign w_timer_clear = (r_state != ST_WRITE) || w_handshake;
  assign w_timer_en    = (r_state == ST_WRITE) && !i_s_valid;

  imem_debug_loader_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_timer_clear),
    .i_en     (w_timer_en),
    .o_expire (w_timer_expire)
  );

  // Next-state and error-cause selection.
  always_comb begin
    w_state_next    = r_state;
    w_err_code_next = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_CHECK;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (r_count == {CNT_W{1'b0}}) begin
          w_state_next = ST_DONE;
        end else if (w_range_bad) begin
          w_state_next    = ST_ERR;
          w_err_code_next = ERR_RANGE;
        end else begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_handshake && w_last) begin
          if (VERIFY) begin
            w_state_next = ST_RD_ISSUE;
          end else begin
            w_state_next = ST_DONE;
          end
        end else if (w_timer_expire) begin
          w_state_next    = ST_ERR;
          w_err_code_next = ERR_TIMEOUT;
        end else begin
          w_state_next = ST_WRITE;
        end
      end
      ST_RD_ISSUE: begin
        if (w_last) begin
          w_state_next = ST_RD_DRAIN;
        end else begin
          w_state_next = ST_RD_ISSUE;
        end
      end
      ST_RD_DRAIN: begin
        // The last read word arrives this cycle, so compare the updated sum.
        if (w_rsum_next == r_wsum) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next    = ST_ERR;
          w_err_code_next = ERR_CSUM;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      ST_ERR:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, counters, checksum accumulators and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_base_idx <= 30'd0;
      r_count    <= {CNT_W{1'b0}};
      r_idx      <= {CNT_W{1'b0}};
      r_wsum     <= 32'd0;
      r_rsum     <= 32'd0;
      r_rd_pend  <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state   <= w_state_next;
      r_rd_pend <= (r_state == ST_RD_ISSUE);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_base_idx <= i_base_addr[31:2];
            r_count    <= i_word_count;
            r_idx      <= {CNT_W{1'b0}};
            r_wsum     <= 32'd0;
            r_rsum     <= 32'd0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
          end
        end
        ST_WRITE: begin
          if (w_handshake) begin
            r_wsum <= r_wsum + i_s_data;
            // Rewind so the read-back pass starts from the first word.
            r_idx  <= w_last ? {CNT_W{1'b0}} : (r_idx + CNT_W'(1));
          end
        end
        ST_RD_ISSUE: begin
          r_idx <= r_idx + CNT_W'(1);
          if (r_rd_pend) begin
            r_rsum <= w_rsum_next;
          end
        end
        ST_RD_DRAIN: r_rsum <= w_rsum_next;
        default: r_rsum <= r_rsum;
      endcase
      if (w_state_next == ST_ERR) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code_next;
      end
    end
  end

  assign o_s_ready   = (r_state == ST_WRITE) && !i_rst;
  assign o_dbg_we    = w_handshake ? 4'hF : 4'h0;
  assign o_dbg_addr  = ((r_state == ST_WRITE) || (r_state == ST_RD_ISSUE)) ?
                       word_to_byte_addr(r_base_idx + 30'(r_idx)) : 32'h0000_0000;
  assign o_dbg_wdata = (r_state == ST_WRITE) ? i_s_data : 32'h0000_0000;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_cpu_halt  = (r_state == ST_CHECK) || (r_state == ST_WRITE) ||
                       (r_state == ST_RD_ISSUE) || (r_state == ST_RD_DRAIN);
  assign o_done      = (r_state == ST_DONE);
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_imem_debug_loader.sv
module tb_imem_debug_loader;

  localparam int MEM_WORDS = 4096;
  localparam int CNT_W     = 13;
  localparam int TIMEOUT   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic [31:0]      dbg_addr;
  logic [31:0]      dbg_wdata;
  logic [3:0]       dbg_we;
  logic [31:0]      dbg_rdata;
  logic             cpu_halt;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [MEM_WORDS];
  int          corrupt_idx = -1;
  logic [31:0] stim_words [64];
  int          stim_gaps  [64];

  typedef struct {
    logic [31:0] base;
    int          count;
    int          gap;        // idle cycles before every word after the first
    int          corrupt_k;  // word offset corrupted on read-back, -1 none
    int          glitch_c;   // cycle of a spurious start during the load, -1 none
    int          exp_code;
    int          exp_cycle;  // cycle (start = 0) where done or err appears
    int          exp_nwr;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  imem_debug_loader #(
    .MEM_WORDS (MEM_WORDS),
    .CNT_W     (CNT_W),
    .VERIFY    (1'b1),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_word_count (word_count),
    .i_s_valid    (s_valid),
    .o_s_ready    (s_ready),
    .i_s_data     (s_data),
    .o_dbg_addr   (dbg_addr),
    .o_dbg_wdata  (dbg_wdata),
    .o_dbg_we     (dbg_we),
    .i_dbg_rdata  (dbg_rdata),
    .o_cpu_halt   (cpu_halt),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_err_code   (err_code)
  );

  // Instruction RAM port B: synchronous write, 1-cycle read, optional corruption.
  always @(posedge clk) begin
    if (dbg_we == 4'hF) mem[dbg_addr[13:2]] <= dbg_wdata;
    dbg_rdata <= mem[dbg_addr[13:2]] ^
                 (((corrupt_idx >= 0) && (int'(dbg_addr[13:2]) == corrupt_idx)) ? 32'h1 : 32'h0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_load(input vec_t v, input string name);
    int          base_idx, nwr, k, gap_left, term_c, nchk;
    bit          term, halt_ok, ram_ok, got_done, got_err, got_halt;
    logic [1:0]  got_code;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [3:0]  wr_we   [64];
    base_idx = int'(v.base[31:2]);
    corrupt_idx = (v.corrupt_k >= 0) ? base_idx + v.corrupt_k : -1;
    nwr = 0; k = 0; gap_left = 0; term = 1'b0; term_c = -1; halt_ok = 1'b1;
    got_done = 1'b0; got_err = 1'b0; got_halt = 1'b1; got_code = 2'd0;
    for (int c = 0; c < 300 && !term; c++) begin
      @(negedge clk);
      start      = (c == 0) || (c == v.glitch_c);
      base_addr  = (c == 0) ? v.base : (v.base ^ 32'h0000_0400);
      word_count = (c == 0) ? CNT_W'(v.count) : CNT_W'(v.count + 3);
      if (k < v.count && gap_left == 0) begin
        s_valid = 1'b1;
        s_data  = stim_words[k];
      end else begin
        s_valid = 1'b0;
        s_data  = $urandom;
        if (gap_left > 0) gap_left--;
      end
      #1;
      if (s_valid && s_ready) begin
        k++;
        gap_left = (k < v.count) ? stim_gaps[k] : 0;
      end
      if (dbg_we != 4'h0) begin
        if (nwr < 64) begin
          wr_addr[nwr] = dbg_addr;
          wr_data[nwr] = dbg_wdata;
          wr_we[nwr]   = dbg_we;
        end
        nwr++;
      end
      if (c > 0 && (done || err)) begin
        term = 1'b1; term_c = c;
        got_done = done; got_err = err; got_code = err_code; got_halt = cpu_halt;
      end else if (c > 0 && !(busy && cpu_halt)) begin
        halt_ok = 1'b0;
      end
    end
    check({name, ".terminated"}, 64'(term), 64'd1);
    check({name, ".cycle"}, 64'(term_c), 64'(v.exp_cycle));
    check({name, ".done"}, 64'(got_done), 64'(v.exp_code == 0));
    check({name, ".err"}, 64'(got_err), 64'(v.exp_code != 0));
    check({name, ".err_code"}, 64'(got_code), 64'(v.exp_code));
    check({name, ".halt_released"}, 64'(got_halt), 64'd0);
    check({name, ".halt_busy_during"}, 64'(halt_ok), 64'd1);
    check({name, ".nwrites"}, 64'(nwr), 64'(v.exp_nwr));
    nchk = (nwr < v.exp_nwr) ? nwr : v.exp_nwr;
    if (nchk > 64) nchk = 64;
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s.wr%0d_addr", name, i), 64'(wr_addr[i]), 64'(32'((base_idx + i) * 4)));
      check($sformatf("%s.wr%0d_data", name, i), 64'(wr_data[i]), 64'(stim_words[i]));
      check($sformatf("%s.wr%0d_we", name, i), 64'(wr_we[i]), 64'(4'hF));
    end
    @(negedge clk);
    start = 1'b0; s_valid = 1'b0;
    #1;
    check({name, ".done_one_cycle"}, 64'(done), 64'd0);
    check({name, ".idle_after"}, 64'(busy), 64'd0);
    check({name, ".err_sticky"}, 64'(err), 64'(v.exp_code != 0));
    check({name, ".code_sticky"}, 64'(err_code), 64'(v.exp_code));
    if (v.exp_code == 0 && v.count > 0) begin
      ram_ok = 1'b1;
      for (int i = 0; i < v.count; i++)
        if (mem[base_idx + i] !== stim_words[i]) ram_ok = 1'b0;
      check({name, ".ram_contents"}, 64'(ram_ok), 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 32'h0; word_count = '0;
    s_valid = 1'b0; s_data = 32'h0;

    //            base          cnt gap crpt glch code cyc nwr
    vecs[0] = '{32'h0000_0100, 4, 0, -1, -1, 0, 11, 4};  // basic verified load
    vecs[1] = '{32'h0000_0100, 4, 0,  1, -1, 3, 11, 4};  // read-back of 0x104 corrupted
    vecs[2] = '{32'h0000_3FFC, 2, 0, -1, -1, 1,  2, 0};  // runs past end of RAM
    vecs[3] = '{32'h0000_0040, 0, 0, -1, -1, 0,  2, 0};  // empty load
    vecs[4] = '{32'h0000_0200, 3, 3, -1, -1, 0, 15, 3};  // 3-cycle gaps
    vecs[5] = '{32'h0000_3FF8, 2, 0, -1, -1, 0,  7, 2};  // ends exactly at last word
    vecs[6] = '{32'h0000_3FFD, 1, 0, -1, -1, 0,  5, 1};  // low address bits ignored
    vecs[7] = '{32'h0000_0000, 4, 8, -1, -1, 2, 11, 1};  // stream stalls TIMEOUT cycles
    vecs[8] = '{32'h0000_0400, 4, 0, -1,  3, 0, 11, 4};  // start pulsed mid-WRITE

    repeat (3) @(negedge clk);
    #1;
    check("reset.we_in_reset", 64'(dbg_we), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.err", 64'({err, err_code}), 64'd0);
    check("reset.cpu_halt", 64'(cpu_halt), 64'd0);
    check("reset.s_ready", 64'(s_ready), 64'd0);
    check("reset.dbg_port", 64'({dbg_we, dbg_addr, dbg_wdata}), 64'd0);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 64; k++) begin
        stim_words[k] = (i == 0) ? 32'(k + 1) : $urandom;
        stim_gaps[k]  = (k == 0) ? 0 : vecs[i].gap;
      end
      run_load(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of WRITE after two words, then a clean load.
    begin
      int   nw;
      vec_t v2;
      nw = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        start = (c == 0); base_addr = 32'h0; word_count = CNT_W'(4);
        s_valid = 1'b1; s_data = 32'hA000_0000 + 32'(c);
        #1;
        if (dbg_we != 4'h0) nw++;
      end
      check("rst_mid.writes_before", 64'(nw), 64'd2);
      @(negedge clk);
      start = 1'b0; rst = 1'b1;
      #1;
      check("rst_mid.we_in_reset", 64'(dbg_we), 64'd0);
      check("rst_mid.ready_in_reset", 64'(s_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0; s_valid = 1'b0;
      #1;
      check("rst_mid.we_after", 64'(dbg_we), 64'd0);
      check("rst_mid.busy_after", 64'(busy), 64'd0);
      check("rst_mid.halt_after", 64'(cpu_halt), 64'd0);
      for (int k = 0; k < 64; k++) begin
        stim_words[k] = $urandom; stim_gaps[k] = 0;
      end
      v2 = '{32'h0000_0080, 3, 0, -1, -1, 0, 9, 3};
      run_load(v2, "rst_mid.reload");
    end

    // Randomised loads checked against arithmetic predictions.
    for (int n = 0; n < 25; n++) begin
      vec_t v;
      int   idx, sumgap;
      idx = ($urandom_range(0, 3) == 0) ? (MEM_WORDS - int'($urandom_range(0, 12)))
                                        : int'($urandom_range(0, MEM_WORDS - 1));
      v.base     = 32'(idx * 4) | 32'($urandom_range(0, 3));
      v.count    = int'($urandom_range(0, 12));
      v.gap      = 0;
      v.glitch_c = -1;
      v.corrupt_k = (v.count > 0 && $urandom_range(0, 3) == 0) ?
                    int'($urandom_range(0, v.count - 1)) : -1;
      sumgap = 0;
      for (int k = 0; k < 64; k++) begin
        stim_words[k] = $urandom;
        stim_gaps[k]  = (k == 0) ? 0 : int'($urandom_range(0, TIMEOUT - 3));
        if (k > 0 && k < v.count) sumgap += stim_gaps[k];
      end
      if (v.count == 0) begin
        v.exp_code = 0; v.exp_cycle = 2; v.exp_nwr = 0;
      end else if (idx + v.count > MEM_WORDS) begin
        v.exp_code = 1; v.exp_cycle = 2; v.exp_nwr = 0;
      end else begin
        v.exp_code  = (v.corrupt_k >= 0) ? 3 : 0;
        v.exp_cycle = 2 * v.count + 3 + sumgap;
        v.exp_nwr   = v.count;
      end
      run_load(v, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
